// File: rtl/dbus_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dbus_ram_arbiter
// Purpose  : Two-master sticky round-robin arbiter for the RAM data port,
//            with bounded bursts and one-cycle read response routing.
// Revision : 1.0 - initial release
// ============================================================================
module dbus_ram_arbiter #(
   parameter int WL        = 32,
   parameter int ADDR_WL   = 13,
   parameter int NB_COL    = WL / 8,
   parameter int MAX_BURST = 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                m0_cmd_valid,
   output logic                m0_cmd_ready,
   input  logic                m0_cmd_wr,
   input  logic [ADDR_WL-1:0]  m0_cmd_addr,
   input  logic [WL-1:0]       m0_cmd_wdata,
   input  logic [NB_COL-1:0]   m0_cmd_be,
   output logic                m0_rsp_valid,
   output logic [WL-1:0]       m0_rsp_data,
   input  logic                m1_cmd_valid,
   output logic                m1_cmd_ready,
   input  logic                m1_cmd_wr,
   input  logic [ADDR_WL-1:0]  m1_cmd_addr,
   input  logic [WL-1:0]       m1_cmd_wdata,
   input  logic [NB_COL-1:0]   m1_cmd_be,
   output logic                m1_rsp_valid,
   output logic [WL-1:0]       m1_rsp_data,
   output logic [NB_COL-1:0]   ram_we,
   output logic [ADDR_WL-1:0]  ram_addr,
   output logic [WL-1:0]       ram_din,
   input  logic [WL-1:0]       ram_dout
);

   localparam int              C_CW  = $clog2(MAX_BURST + 1);
   localparam logic [C_CW-1:0] C_MAX = C_CW'(MAX_BURST);

   logic            r_last;
   logic [C_CW-1:0] r_burst_cnt;
   logic            r_rsp_pend;
   logic            r_rsp_owner;

   logic w_gnt;
   logic w_g;
   logic w_wr;

   // With no requester w_g falls to 0, so the RAM port idles on master 0's fields.
   always_comb begin
      w_gnt = resetn & (m0_cmd_valid | m1_cmd_valid);
      w_g   = m1_cmd_valid;
      if (m0_cmd_valid && m1_cmd_valid)
         w_g = (r_burst_cnt == C_MAX) ? ~r_last : r_last;
      w_wr     = w_g ? m1_cmd_wr : m0_cmd_wr;
      ram_addr = w_g ? m1_cmd_addr : m0_cmd_addr;
      ram_din  = w_g ? m1_cmd_wdata : m0_cmd_wdata;
      ram_we   = '0;
      if (w_gnt && w_wr)
         ram_we = w_g ? m1_cmd_be : m0_cmd_be;
      m0_cmd_ready = w_gnt & ~w_g;
      m1_cmd_ready = w_gnt & w_g;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_last      <= 1'b0;
         r_burst_cnt <= '0;
         r_rsp_pend  <= 1'b0;
         r_rsp_owner <= 1'b0;
      end else begin
         r_rsp_pend <= w_gnt & ~w_wr;
         if (w_gnt) begin
            if (!w_wr)
               r_rsp_owner <= w_g;
            if (w_g == r_last) begin
               if (r_burst_cnt != C_MAX)
                  r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
               r_last      <= w_g;
               r_burst_cnt <= C_CW'(1);
            end
         end
      end
   end

   assign m0_rsp_valid = resetn & r_rsp_pend & ~r_rsp_owner;
   assign m1_rsp_valid = resetn & r_rsp_pend & r_rsp_owner;
   assign m0_rsp_data  = ram_dout;
   assign m1_rsp_data  = ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_dbus_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_ram_arbiter
// Purpose  : Directed self-checking bench for dbus_ram_arbiter (MAX_BURST=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dbus_ram_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_rsp_valid;
   logic [12:0] m0_cmd_addr;
   logic [31:0] m0_cmd_wdata, m0_rsp_data;
   logic [3:0]  m0_cmd_be;
   logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_rsp_valid;
   logic [12:0] m1_cmd_addr;
   logic [31:0] m1_cmd_wdata, m1_rsp_data;
   logic [3:0]  m1_cmd_be;
   logic [3:0]  ram_we;
   logic [12:0] ram_addr;
   logic [31:0] ram_din, ram_dout;
   logic [31:0] mem [0:8191];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dbus_ram_arbiter #(.WL(32), .ADDR_WL(13), .NB_COL(4), .MAX_BURST(4)) dut (
      .clk(clk), .resetn(resetn),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_wr(m0_cmd_wr),
      .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_be(m0_cmd_be),
      .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_wr(m1_cmd_wr),
      .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_be(m1_cmd_be),
      .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   // Byte-lane RAM with registered read data.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
      ram_dout <= mem[ram_addr];
   end

   function automatic logic [31:0] pat(input int a);
      return 32'hC0DE0000 ^ a;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drv0(input logic v, input logic wr, input int a, input logic [31:0] d, input logic [3:0] be);
      m0_cmd_valid = v; m0_cmd_wr = wr; m0_cmd_addr = 13'(a); m0_cmd_wdata = d; m0_cmd_be = be;
   endtask

   task automatic drv1(input logic v, input logic wr, input int a, input logic [31:0] d, input logic [3:0] be);
      m1_cmd_valid = v; m1_cmd_wr = wr; m1_cmd_addr = 13'(a); m1_cmd_wdata = d; m1_cmd_be = be;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
      step(); step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      drv0(1, 1, 1, 32'h1, 4'hF); drv1(1, 1, 2, 32'h2, 4'hF);
      step(); #3;
      checks++;
      if ({m0_cmd_ready, m1_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: got rdy=%b%b we=%h rsp=%b%b want all 0",
                  m0_cmd_ready, m1_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid);
      end
      step();
      resetn = 1'b1;
   endtask

   task automatic test_single_read();
      drv0(1, 1, 5, 32'hDEADBEEF, 4'hF); drv1(0, 0, 0, 0, 0); #3;
      checks++;
      if ({m0_cmd_ready, m1_cmd_ready, ram_we, ram_addr} !== {2'b10, 4'hF, 13'd5}) begin
         failures++;
         $display("FAIL single_write: rdy=%b%b we=%h addr=%0d want rdy=10 we=f addr=5",
                  m0_cmd_ready, m1_cmd_ready, ram_we, ram_addr);
      end
      step();
      drv0(1, 0, 5, 0, 4'hF); #3;
      checks++;
      if ({m0_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid} !== 7'b1_0000_00) begin
         failures++;
         $display("FAIL single_read_cmd: rdy=%b we=%h rsp=%b%b want rdy=1 we=0 rsp=00",
                  m0_cmd_ready, ram_we, m0_rsp_valid, m1_rsp_valid);
      end
      step();
      drv0(0, 0, 0, 0, 0); #3;
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL single_read_rsp: rsp=%b%b data=%h want rsp=10 data=deadbeef",
                  m0_rsp_valid, m1_rsp_valid, m0_rsp_data);
      end
      step(); #3;
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL single_rsp_once: rsp=%b%b want 00", m0_rsp_valid, m1_rsp_valid);
      end
      step();
   endtask

   task automatic test_contention();
      logic eg, pg;
      int   pa;
      pg = 0; pa = 0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drv0(1, 0, 40 + i, 0, 0); drv1(1, 0, 140 + i, 0, 0); #3;
         eg = ((i / 4) % 2) == 1;
         checks++;
         if ({m0_cmd_ready, m1_cmd_ready, ram_addr} !== {~eg, eg, 13'(eg ? 140 + i : 40 + i)}) begin
            failures++;
            $display("FAIL contention_grant[%0d]: rdy=%b%b addr=%0d want rdy=%b%b", i,
                     m0_cmd_ready, m1_cmd_ready, ram_addr, ~eg, eg);
         end
         if (i > 0) begin
            checks++;
            if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_data} !== {~pg, pg, pat(pa)}) begin
               failures++;
               $display("FAIL contention_rsp[%0d]: rsp=%b%b data=%h want rsp=%b%b data=%h", i,
                        m0_rsp_valid, m1_rsp_valid, m0_rsp_data, ~pg, pg, pat(pa));
            end
         end
         pg = eg; pa = eg ? 140 + i : 40 + i;
         step();
      end
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0); #3;
      checks++;
      if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_data} !== {~pg, pg, pat(pa)}) begin
         failures++;
         $display("FAIL contention_last_rsp: rsp=%b%b data=%h want %b%b %h",
                  m0_rsp_valid, m1_rsp_valid, m0_rsp_data, ~pg, pg, pat(pa));
      end
      step();
   endtask

   task automatic test_byte_enables();
      drv1(1, 1, 0, 32'h11223344, 4'hF); step();
      drv1(1, 1, 0, 32'hAABBCCDD, 4'b0101); #3;
      checks++;
      if ({m1_cmd_ready, ram_we} !== 5'b1_0101) begin
         failures++;
         $display("FAIL be_write: rdy=%b we=%b want rdy=1 we=0101", m1_cmd_ready, ram_we);
      end
      step();
      drv1(0, 0, 0, 0, 0); drv0(1, 0, 0, 0, 0); step();
      drv0(0, 0, 0, 0, 0); #3;
      checks++;
      if ({m0_rsp_valid, m0_rsp_data} !== {1'b1, 32'h11BB33DD}) begin
         failures++;
         $display("FAIL be_read: rsp=%b data=%h want 1 11bb33dd", m0_rsp_valid, m0_rsp_data);
      end
      step();
   endtask

   task automatic test_lone_midrun();
      logic [6:0] v0;
      logic [6:0] eg;
      v0 = 7'b1111011;  // bit i: m0 valid in cycle i; m1 always valid
      eg = 7'b0111100;  // bit i: m1 expected to win cycle i
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drv0(v0[i], 1, 200 + i, 32'h0, 4'hF); drv1(1, 1, 220 + i, 32'h0, 4'hF); #3;
         checks++;
         if ({m0_cmd_ready, m1_cmd_ready} !== {~eg[i], eg[i]}) begin
            failures++;
            $display("FAIL lone_midrun[%0d]: rdy=%b%b want %b%b", i,
                     m0_cmd_ready, m1_cmd_ready, ~eg[i], eg[i]);
         end
         step();
      end
   endtask

   // Follows test_lone_midrun: state is last=m0, burst count 1.
   task automatic test_idle();
      drv0(0, 1, 7, 32'h77, 4'hF); drv1(0, 1, 9, 32'h99, 4'hF);
      for (int i = 0; i < 10; i++) begin
         #3;
         checks++;
         if ({m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, ram_we, ram_addr, ram_din}
             !== {4'b0000, 4'h0, 13'd7, 32'h77}) begin
            failures++;
            $display("FAIL idle[%0d]: rdy=%b%b rsp=%b%b we=%h addr=%0d din=%h want 0 0 0 7 77", i,
                     m0_cmd_ready, m1_cmd_ready, m0_rsp_valid, m1_rsp_valid, ram_we, ram_addr, ram_din);
         end
         step();
      end
      for (int i = 0; i < 4; i++) begin
         drv0(1, 1, 240 + i, 0, 4'hF); drv1(1, 1, 250 + i, 0, 4'hF); #3;
         checks++;
         if ({m0_cmd_ready, m1_cmd_ready} !== ((i < 3) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL idle_state_kept[%0d]: rdy=%b%b want %b", i, m0_cmd_ready, m1_cmd_ready,
                     (i < 3) ? 2'b10 : 2'b01);
         end
         step();
      end
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
   endtask

   task automatic test_reset_midread();
      drv1(1, 0, 300, 0, 0); #3;
      checks++;
      if (m1_cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_read_accept: rdy=%b want 1", m1_cmd_ready);
      end
      step();
      resetn = 1'b0;
      drv1(0, 0, 0, 0, 0); #3;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL rst_rsp_cancel[%0d]: rsp=%b%b want 00", i, m0_rsp_valid, m1_rsp_valid);
         end
         step();
         if (i == 1) resetn = 1'b1;
         #3;
      end
      for (int i = 0; i < 5; i++) begin
         drv0(1, 1, 260 + i, 0, 4'hF); drv1(1, 1, 270 + i, 0, 4'hF); #3;
         checks++;
         if ({m0_cmd_ready, m1_cmd_ready} !== ((i < 4) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL rst_first_grant[%0d]: rdy=%b%b want %b", i, m0_cmd_ready, m1_cmd_ready,
                     (i < 4) ? 2'b10 : 2'b01);
         end
         step();
      end
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = pat(a);
      drv0(0, 0, 0, 0, 0); drv1(0, 0, 0, 0, 0);
      test_reset();
      test_single_read();
      test_contention();
      test_byte_enables();
      test_lone_midrun();
      test_idle();
      test_reset_midread();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dbus_ram_arbiter.md
# dbus_ram_arbiter

Two-master arbiter that shares the single data port of the VexRiscv instruction/data RAM between the CPU data bus (master 0) and a second word-addressed master (master 1, e.g. a UART boot loader or debug DMA). It sits between the byte-lane translation logic and the RAM data port. It grants one command per cycle using sticky round-robin with a bounded burst length, and it routes each one-cycle-latency read response back to the master that issued it.

## Interface
- `WL`, 32, data word width in bits.
- `ADDR_WL`, 13, RAM word-address width.
- `NB_COL`, `WL/8`, number of byte lanes (write-enable width).
- `MAX_BURST`, 8, maximum consecutive grants to one master while the other is requesting; legal range ≥1.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `m0_cmd_valid`  in  1  master 0 command request.
- `m0_cmd_ready`  out  1  master 0 command accepted this cycle.
- `m0_cmd_wr`  in  1  1 = write, 0 = read.
- `m0_cmd_addr`  in  ADDR_WL  word address.
- `m0_cmd_wdata`  in  WL  write data.
- `m0_cmd_be`  in  NB_COL  byte enables; ignored for reads.
- `m0_rsp_valid`  out  1  read data valid.
- `m0_rsp_data`  out  WL  read data.
- `m1_*`  same set, same widths, for master 1.
- `ram_we`  out  NB_COL  RAM byte write enables.
- `ram_addr`  out  ADDR_WL  RAM word address.
- `ram_din`  out  WL  RAM write data.
- `ram_dout`  in  WL  RAM read data; registered, valid the cycle after the address.

## Operation
- State registers:
  - `last`: 1 bit, index of the most recently granted master. Reset value 0.
  - `burst_cnt`: clog2(MAX_BURST+1) bits, saturating. Reset value 0.
  - `rsp_pend`: 1 bit. Reset value 0.
  - `rsp_owner`: 1 bit. Reset value 0.
- Grant selection is combinational within the cycle:
  - Neither master valid: no grant. `ram_we=0`, `ram_addr=m0_cmd_addr`, `ram_din=m0_cmd_wdata`.
  - Exactly one master valid: that master is granted.
  - Both valid and `burst_cnt < MAX_BURST`: `last` is granted.
  - Both valid and `burst_cnt == MAX_BURST`: `~last` is granted.
- For the granted master g:
  - `mg_cmd_ready=1`; the other master's ready is 0.
  - RAM outputs are muxed from g.
  - `ram_we = be` if `wr`, else 0.
- On each grant:
  - If g == `last`: `burst_cnt <= min(burst_cnt+1, MAX_BURST)`.
  - Otherwise: `last <= g`, `burst_cnt <= 1`.
  - With no grant, `burst_cnt` and `last` hold.
- Reads:
  - An accepted read sets `rsp_pend <= 1` and `rsp_owner <= g`.
  - Any other cycle clears `rsp_pend`.
- Writes produce no response.
- Response outputs:
  - `mX_rsp_valid = rsp_pend && rsp_owner==X`.
  - `mX_rsp_data = ram_dout` for both masters (unqualified).
- While `resetn` is low:
  - All registers are held at their reset values.
  - All `cmd_ready`, `rsp_valid` and `ram_we` outputs are forced to 0.

## Timing
- Command handshake: the command transfers on the rising edge where `valid && ready`.
- `ready` depends combinationally on both masters' `valid`. A master must not make `valid` depend on `ready`.
- Write latency: the RAM write occurs at the acceptance edge.
- Read latency: `rsp_valid` is high exactly 1 cycle after acceptance, for 1 cycle. There is no response backpressure.
- Throughput: back-to-back commands (read or write, any master mix) are accepted every cycle with no bubbles. Responses pipeline one per cycle.
- Master switches: a switch costs no idle cycle.
- Fairness bound: with both masters continuously valid, grants alternate in runs of exactly MAX_BURST.
  - The first run after reset goes to m0.
  - The first run length is MAX_BURST because `burst_cnt` starts at 0 and is incremented on grant 1 with g == `last`.
- A requester's `valid` dropping mid-run ends the run. The next lone requester is granted immediately.
- Asynchronous reset:
  - Asserting `resetn` while a read is in flight cancels its response. No `rsp_valid` appears after deassertion.
  - After deassertion, the first cycle may grant.

## Test plan
- **Single-master read, m0 only:** write `0xDEADBEEF` to address 5 with `be=4'hF`, then read address 5 → `m0_rsp_valid` 1 cycle after acceptance, data `0xDEADBEEF`; `m1_rsp_valid` stays 0.
- **Contention, `MAX_BURST=4`, both valid for 20 cycles:**
  - Grant sequence is m0×4, m1×4, m0×4, m1×4, m0×4.
  - Every cycle has exactly one ready.
  - Responses return to the issuer in order.
- **Byte enables:** m1 writes `0x11223344` (`be=F`) to address 0, then m1 writes `0xAABBCCDD` with `be=4'b0101`, then m0 reads address 0 → `0x11BB33DD`.
- **Lone requester mid-run:**
  - m0 is granted 2 of 4 in its run, then drops `valid` while m1 is valid → m1 is granted the next cycle.
  - m0 then reasserts while m1 continues → m1 keeps the grant until its run reaches 4 (count restarted at 1).
- **Idle bus:** no `valid` for 10 cycles → `ram_we=0`, all ready 0, all `rsp_valid` 0, and `last`/`burst_cnt` are unchanged.
- **Reset mid-read:**
  - m1 read is accepted, then `resetn` is pulsed low before the next edge → `m1_rsp_valid` never asserts.
  - After release, `last=0` and `burst_cnt=0`, so the first contended grant goes to m0.
